// File: rtl/ibex_instr_realigner.sv
// ============================================================================
// ibex_instr_realigner
// Splits word-aligned fetch data into individual 16/32-bit instructions with PCs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ibex_instr_realigner #(
    parameter logic [31:0] BootAddr = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_addr_o,
    output logic        out_is_compressed_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    logic [31:0] pc_q;
    logic        offset_q;
    logic        stash_valid_q;
    logic [15:0] stash_q;
    logic        stash_err_q;

    logic [31:0] cand_instr;
    logic        cand_err;
    logic        cand_err_plus2;
    logic        produce;
    logic        consume;
    logic        stash_load;
    logic        next_offset;
    logic [31:0] pc_inc;
    logic        fire;

    always_comb begin
        cand_instr     = 32'h0;
        cand_err       = 1'b0;
        cand_err_plus2 = 1'b0;
        produce        = 1'b0;
        consume        = 1'b0;
        stash_load     = 1'b0;
        next_offset    = 1'b0;
        pc_inc         = 32'd2;
        if (stash_valid_q) begin
            // Upper half of a straddling instruction arrives in the lower halfword.
            cand_instr     = {in_rdata_i[15:0], stash_q};
            cand_err       = stash_err_q | in_err_i;
            cand_err_plus2 = in_err_i & ~stash_err_q;
            produce        = 1'b1;
            next_offset    = 1'b1;
            pc_inc         = 32'd4;
        end else if (!offset_q) begin
            produce  = 1'b1;
            cand_err = in_err_i;
            if (in_rdata_i[1:0] != 2'b11) begin
                cand_instr  = {16'h0, in_rdata_i[15:0]};
                next_offset = 1'b1;
            end else begin
                cand_instr = in_rdata_i;
                consume    = 1'b1;
                pc_inc     = 32'd4;
            end
        end else begin
            cand_instr = {16'h0, in_rdata_i[31:16]};
            if (in_rdata_i[17:16] != 2'b11 || in_err_i) begin
                // An erroring first half is reported at once instead of waiting.
                produce  = 1'b1;
                consume  = 1'b1;
                cand_err = in_err_i;
            end else begin
                stash_load = 1'b1;
            end
        end
    end

    assign out_valid_o         = rst_ni & ~clear_i & in_valid_i & produce;
    assign fire                = out_valid_o & out_ready_i;
    assign in_ready_o          = rst_ni & (clear_i | (in_valid_i & (stash_load | (fire & consume))));
    assign out_instr_o         = rst_ni ? cand_instr : 32'h0;
    assign out_addr_o          = rst_ni ? pc_q : 32'h0;
    assign out_is_compressed_o = rst_ni & (cand_instr[1:0] != 2'b11);
    assign out_err_o           = rst_ni & cand_err;
    assign out_err_plus2_o     = rst_ni & cand_err_plus2;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q          <= {BootAddr[31:1], 1'b0};
            offset_q      <= BootAddr[1];
            stash_valid_q <= 1'b0;
            stash_q       <= 16'h0;
            stash_err_q   <= 1'b0;
        end else if (clear_i) begin
            pc_q          <= {clear_addr_i[31:1], 1'b0};
            offset_q      <= clear_addr_i[1];
            stash_valid_q <= 1'b0;
        end else if (in_valid_i && stash_load) begin
            stash_q       <= in_rdata_i[31:16];
            stash_err_q   <= in_err_i;
            stash_valid_q <= 1'b1;
            offset_q      <= 1'b0;
        end else if (fire) begin
            pc_q          <= pc_q + pc_inc;
            offset_q      <= next_offset;
            stash_valid_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibex_instr_realigner.sv
// ============================================================================
// tb_ibex_instr_realigner
// Directed self-checking bench for the instruction realigner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ibex_instr_realigner;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic [31:0] clear_addr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_is_compressed_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    int vectors     = 0;
    int miscompares = 0;

    ibex_instr_realigner #(.BootAddr(32'h0000_0080)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .clear_i             (clear_i),
        .clear_addr_i        (clear_addr_i),
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .in_rdata_i          (in_rdata_i),
        .in_err_i            (in_err_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_instr_o         (out_instr_o),
        .out_addr_o          (out_addr_o),
        .out_is_compressed_o (out_is_compressed_o),
        .out_err_o           (out_err_o),
        .out_err_plus2_o     (out_err_plus2_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full check of the handshake and output bundle at the current settle point.
    task automatic chk_out(input string tag, input logic v, input logic r,
                           input logic [31:0] instr, input logic [31:0] addr,
                           input logic comp, input logic err, input logic errp2);
        chk({tag, ".valid"}, {31'h0, out_valid_o}, {31'h0, v});
        chk({tag, ".ready"}, {31'h0, in_ready_o}, {31'h0, r});
        chk({tag, ".instr"}, out_instr_o, instr);
        chk({tag, ".addr"}, out_addr_o, addr);
        chk({tag, ".comp"}, {31'h0, out_is_compressed_o}, {31'h0, comp});
        chk({tag, ".err"}, {31'h0, out_err_o}, {31'h0, err});
        chk({tag, ".errp2"}, {31'h0, out_err_plus2_o}, {31'h0, errp2});
    endtask

    task automatic drive(input logic clr, input logic [31:0] caddr, input logic iv,
                         input logic [31:0] w, input logic e, input logic ordy);
        clear_i      = clr;
        clear_addr_i = caddr;
        in_valid_i   = iv;
        in_rdata_i   = w;
        in_err_i     = e;
        out_ready_i  = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h0001_4501, 1'b0, 1'b1);
        chk_out("reset", 0, 0, 32'h0, 32'h0, 0, 0, 0);
        tick();
        rst_ni = 1'b1;

        // Two compressed instructions in one word
        drive(1'b0, 32'h0, 1'b1, 32'h0001_4501, 1'b0, 1'b1);
        chk_out("c0", 1, 0, 32'h0000_4501, 32'h80, 1, 0, 0);
        tick();
        chk_out("c1", 1, 1, 32'h0000_0001, 32'h82, 1, 0, 0);
        tick();

        // 32-bit instruction with back-pressure
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_out("stall", 1, 0, 32'h0000_0513, 32'h84, 0, 0, 0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 1'b1);
        chk_out("w32", 1, 1, 32'h0000_0513, 32'h84, 0, 0, 0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0000_0513, 1'b0, 1'b1);
        chk_out("idle", 0, 0, 32'h0000_0513, 32'h88, 0, 0, 0);

        // Straddling instruction from 0x102
        drive(1'b1, 32'h0000_0102, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        chk("clr.valid", {31'h0, out_valid_o}, 32'h0);
        chk("clr.ready", {31'h0, in_ready_o}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0513_1234, 1'b0, 1'b1);
        chk("stash.valid", {31'h0, out_valid_o}, 32'h0);
        chk("stash.ready", {31'h0, in_ready_o}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b0, 1'b1);
        chk_out("strad", 1, 0, 32'h0000_0513, 32'h102, 0, 0, 0);
        tick();
        chk_out("after", 1, 1, 32'h0000_4501, 32'h106, 1, 0, 0);
        tick();

        // Error in second half of a straddling instruction
        drive(1'b1, 32'h0000_0302, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0513_0000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b1, 1'b1);
        chk_out("errp2", 1, 0, 32'h0000_0513, 32'h302, 0, 1, 1);
        tick();
        chk_out("errc", 1, 1, 32'h0000_4501, 32'h306, 1, 1, 0);
        tick();

        // Error on the first half of a 32-bit instruction at offset 1
        drive(1'b1, 32'h0000_0402, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0513_0000, 1'b1, 1'b1);
        chk_out("errfirst", 1, 1, 32'h0000_0513, 32'h402, 0, 1, 0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        chk_out("errnext", 1, 0, 32'h0000_0001, 32'h404, 1, 0, 0);

        // Clear while the stash holds a halfword and an output is pending
        drive(1'b1, 32'h0000_0502, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0513_0000, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b0, 1'b1);
        chk("pre.valid", {31'h0, out_valid_o}, 32'h1);
        drive(1'b1, 32'h0000_0200, 1'b1, 32'h4501_0000, 1'b0, 1'b1);
        chk("clrst.valid", {31'h0, out_valid_o}, 32'h0);
        chk("clrst.ready", {31'h0, in_ready_o}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 1'b1);
        chk_out("postclr", 1, 1, 32'h0000_0513, 32'h200, 0, 0, 0);
        tick();

        // PC wrap
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 1'b1);
        chk_out("wrap", 1, 1, 32'h0000_0513, 32'hFFFF_FFFC, 0, 0, 0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0000_0513, 1'b0, 1'b1);
        chk("wrap.addr", out_addr_o, 32'h0);
        chk("wrap.valid", {31'h0, out_valid_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
